// File: rtl/method_if_pkg.sv
// Shared types and constants for method-call responders: FSM state encoding,
// counter sizing helper and the divide-by-zero quotient pattern.
package method_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_WIDTH     = 64;

    // All-ones quotient reported for a zero divisor; sliced to the operand width.
    localparam logic [MAX_WIDTH-1:0] DIV_BY_ZERO_QUOT = '1;

    // Step-counter width; the counter has to hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/method_div_responder_if.sv
// Method-call bundle for `div`: the caller drives req and operands, the responder
// answers with busy, quotient, remainder and the divide-by-zero flag.
interface method_div_responder_if import method_if_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             div_req;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_busy;
    logic [WIDTH-1:0] div_return;
    logic [WIDTH-1:0] div_remainder;
    logic             div_by_zero;

    modport master (
        output div_req, div_a, div_b,
        input  div_busy, div_return, div_remainder, div_by_zero
    );

    modport slave (
        input  div_req, div_a, div_b,
        output div_busy, div_return, div_remainder, div_by_zero
    );
endinterface

// File: rtl/method_div_responder_handshake.sv
// Reusable callee handshake: accepts a level request once per arming, holds busy
// until the method datapath signals finish, and rearms only after req drops.
module method_handshake (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic finish,
    output logic accept,
    output logic busy
);
    logic armed_q, armed_d;
    logic busy_q, busy_d;

    always_comb begin
        armed_d = armed_q;
        busy_d  = busy_q;
        accept  = !busy_q && armed_q && req;
        if (accept) begin
            busy_d  = 1'b1;
            armed_d = 1'b0;
        end else if (!busy_q && !req) begin
            armed_d = 1'b1;
        end
        // finish only occurs while busy, so it never collides with accept.
        if (finish) busy_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/method_div_responder.sv
// Responder for method `div`: iterative restoring divider, one quotient bit per cycle.
// Define METHOD_DIV_SIGNED_EN for two's-complement operands (adds a FIXUP step).
module method_div_responder import method_if_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    method_div_responder_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] return_q, return_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             by_zero_q, by_zero_d;
    logic             zero_div_q, zero_div_d;
    logic [CNT_W-1:0] count_q, count_d;
`ifdef METHOD_DIV_SIGNED_EN
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic             accept;
    logic             finish;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    method_handshake u_handshake (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.div_req),
        .finish (finish),
        .accept (accept),
        .busy   (bus.div_busy)
    );

    assign finish = (state_q == DONE);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        divisor_d   = divisor_q;
        dividend_d  = dividend_q;
        return_d    = return_q;
        remainder_d = remainder_q;
        by_zero_d   = by_zero_q;
        zero_div_d  = zero_div_q;
        count_d     = count_q;
`ifdef METHOD_DIV_SIGNED_EN
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
`endif
        // Extra top bit keeps the trial subtraction's borrow visible.
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor_q};
        borrow  = trial[WIDTH+1];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dividend_d = bus.div_a;
                    rem_d      = '0;
`ifdef METHOD_DIV_SIGNED_EN
                    quot_d     = bus.div_a[WIDTH-1] ? -bus.div_a : bus.div_a;
                    divisor_d  = bus.div_b[WIDTH-1] ? -bus.div_b : bus.div_b;
                    neg_quot_d = bus.div_a[WIDTH-1] ^ bus.div_b[WIDTH-1];
                    neg_rem_d  = bus.div_a[WIDTH-1];
`else
                    quot_d     = bus.div_a;
                    divisor_d  = bus.div_b;
`endif
                    count_d    = CNT_W'(WIDTH - 1);
                    zero_div_d = (bus.div_b == '0);
                    state_d    = zero_div_d ? DONE : CALC;
                end
            end
            CALC: begin
                rem_d   = borrow ? shifted[WIDTH-1:0] : WIDTH'(trial);
                quot_d  = {quot_q[WIDTH-2:0], ~borrow};
                count_d = count_q - CNT_W'(1);
                if (count_q == '0) begin
`ifdef METHOD_DIV_SIGNED_EN
                    state_d = FIXUP;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef METHOD_DIV_SIGNED_EN
            FIXUP: begin
                if (neg_quot_q) quot_d = -quot_q;
                if (neg_rem_q)  rem_d  = -rem_q;
                state_d = DONE;
            end
`endif
            DONE: begin
                return_d    = zero_div_q ? DIV_BY_ZERO_QUOT[WIDTH-1:0] : quot_q;
                remainder_d = zero_div_q ? dividend_q : rem_q;
                by_zero_d   = zero_div_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quot_q      <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            return_q    <= '0;
            remainder_q <= '0;
            by_zero_q   <= 1'b0;
            zero_div_q  <= 1'b0;
            count_q     <= '0;
`ifdef METHOD_DIV_SIGNED_EN
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            divisor_q   <= divisor_d;
            dividend_q  <= dividend_d;
            return_q    <= return_d;
            remainder_q <= remainder_d;
            by_zero_q   <= by_zero_d;
            zero_div_q  <= zero_div_d;
            count_q     <= count_d;
`ifdef METHOD_DIV_SIGNED_EN
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign bus.div_return    = return_q;
    assign bus.div_remainder = remainder_q;
    assign bus.div_by_zero   = by_zero_q;

endmodule

// File: tb/tb_method_div_responder.sv
// Self-checking bench for method_div_responder (WIDTH=32); follows METHOD_DIV_SIGNED_EN
// so the reference model matches the build under test.
module tb_method_div_responder;
    localparam int W       = 32;
    localparam int TIMEOUT = 200;
`ifdef METHOD_DIV_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    method_div_responder_if #(.WIDTH(W)) bus ();

    method_div_responder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: plain integer arithmetic on the operands as the caller sees them.
    task automatic model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] q, output logic [W-1:0] r,
                             output logic z, output int lat);
`ifdef METHOD_DIV_SIGNED_EN
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`endif
        if (b == '0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            z = 1'b0;
`ifdef METHOD_DIV_SIGNED_EN
            q = W'(sa / sb); r = W'(sa % sb); lat = W + 2;
`else
            q = a / b; r = a % b; lat = W + 1;
`endif
        end
    endtask

    task automatic start_call(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.div_a   = a;
        bus.div_b   = b;
        bus.div_req = 1'b1;
    endtask

    // Counts falling-edge samples with busy high; returns on the first idle sample.
    task automatic wait_busy(input bit churn, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (bus.div_busy === 1'b1 && cycles < TIMEOUT) begin
            cycles++;
            if (churn) begin
                bus.div_a   = $urandom;
                bus.div_b   = $urandom;
                bus.div_req = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic end_call();
        bus.div_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.div_req = 1'b0; bus.div_a = '0; bus.div_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.div_busy); end
        checks++; if (bus.div_return !== '0) begin errors++; $display("FAIL reset return: got %h expected 0", bus.div_return); end
        checks++; if (bus.div_remainder !== '0) begin errors++; $display("FAIL reset remainder: got %h expected 0", bus.div_remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset by_zero: got %b expected 0", bus.div_by_zero); end
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        while (cyc < 99) @(negedge clk);
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b expected 0", bus.div_busy); end
    endtask

    task automatic test_basic();
        int n;
        start_call(32'd100, 32'd7);
        wait_busy(1'b0, n);
        checks++; if (n != LAT) begin errors++; $display("FAIL basic latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus.div_return !== 32'd14) begin errors++; $display("FAIL basic return: got %0d expected 14", bus.div_return); end
        checks++; if (bus.div_remainder !== 32'd2) begin errors++; $display("FAIL basic remainder: got %0d expected 2", bus.div_remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic by_zero: got %b expected 0", bus.div_by_zero); end
        end_call();
    endtask

    task automatic test_div_by_zero();
        int n;
        start_call(32'h1234, 32'd0);
        wait_busy(1'b0, n);
        checks++; if (n != 1) begin errors++; $display("FAIL dbz latency: got %0d expected 1", n); end
        checks++; if (bus.div_return !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz return: got %h expected ffffffff", bus.div_return); end
        checks++; if (bus.div_remainder !== 32'h1234) begin errors++; $display("FAIL dbz remainder: got %h expected 1234", bus.div_remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz flag: got %b expected 1", bus.div_by_zero); end
        end_call();
        start_call(32'd9, 32'd3);
        wait_busy(1'b0, n);
        checks++; if (n != LAT) begin errors++; $display("FAIL after_dbz latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus.div_return !== 32'd3) begin errors++; $display("FAIL after_dbz return: got %0d expected 3", bus.div_return); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL after_dbz flag: got %b expected 0", bus.div_by_zero); end
        end_call();
    endtask

    task automatic test_req_held();
        int n;
        int extra;
        start_call(32'hFFFF_FFFF, 32'd1);
        wait_busy(1'b0, n);
        checks++; if (n != LAT) begin errors++; $display("FAIL held latency: got %0d expected %0d", n, LAT); end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.div_busy !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL held restart: got %0d busy cycles expected 0", extra); end
        checks++; if (bus.div_return !== 32'hFFFF_FFFF) begin errors++; $display("FAIL held return: got %h expected ffffffff", bus.div_return); end
        checks++; if (bus.div_remainder !== 32'd0) begin errors++; $display("FAIL held remainder: got %h expected 0", bus.div_remainder); end
        end_call();
        start_call(32'hFFFF_FFFF, 32'd1);
        wait_busy(1'b0, n);
        checks++; if (n != LAT) begin errors++; $display("FAIL rearm latency: got %0d expected %0d", n, LAT); end
        end_call();
    endtask

    task automatic test_reset_mid();
        int n;
        start_call(32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b expected 0", bus.div_busy); end
        checks++; if (bus.div_return !== '0) begin errors++; $display("FAIL midreset return: got %h expected 0", bus.div_return); end
        checks++; if (bus.div_remainder !== '0) begin errors++; $display("FAIL midreset remainder: got %h expected 0", bus.div_remainder); end
        bus.div_a = 32'd50;
        bus.div_b = 32'd5;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_busy(1'b0, n);
        checks++; if (n != LAT) begin errors++; $display("FAIL postreset latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus.div_return !== 32'd10) begin errors++; $display("FAIL postreset return: got %0d expected 10", bus.div_return); end
        end_call();
    endtask

    task automatic test_operand_churn();
        int n;
        start_call(32'd1000, 32'd10);
        wait_busy(1'b1, n);
        bus.div_req = 1'b0;
        checks++; if (n != LAT) begin errors++; $display("FAIL churn latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus.div_return !== 32'd100) begin errors++; $display("FAIL churn return: got %0d expected 100", bus.div_return); end
        checks++; if (bus.div_remainder !== 32'd0) begin errors++; $display("FAIL churn remainder: got %0d expected 0", bus.div_remainder); end
        end_call();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic         ez;
        int           elat, n;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            model_div(a, b, eq, er, ez, elat);
            start_call(a, b);
            wait_busy(1'b0, n);
            checks++; if (n != elat) begin errors++; $display("FAIL rand%0d latency: got %0d expected %0d", i, n, elat); end
            checks++; if (bus.div_return !== eq) begin errors++; $display("FAIL rand%0d return: %h/%h got %h expected %h", i, a, b, bus.div_return, eq); end
            checks++; if (bus.div_remainder !== er) begin errors++; $display("FAIL rand%0d remainder: %h/%h got %h expected %h", i, a, b, bus.div_remainder, er); end
            checks++; if (bus.div_by_zero !== ez) begin errors++; $display("FAIL rand%0d by_zero: got %b expected %b", i, bus.div_by_zero, ez); end
            end_call();
        end
    endtask

`ifdef METHOD_DIV_SIGNED_EN
    task automatic test_signed();
        int n;
        start_call(-32'sd7, 32'sd2);
        wait_busy(1'b0, n);
        checks++; if (n != W + 2) begin errors++; $display("FAIL signed latency: got %0d expected %0d", n, W + 2); end
        checks++; if (bus.div_return !== 32'hFFFF_FFFD) begin errors++; $display("FAIL signed return: got %h expected fffffffd", bus.div_return); end
        checks++; if (bus.div_remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed remainder: got %h expected ffffffff", bus.div_remainder); end
        end_call();
        start_call(32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(1'b0, n);
        checks++; if (bus.div_return !== 32'h8000_0000) begin errors++; $display("FAIL min_neg1 return: got %h expected 80000000", bus.div_return); end
        checks++; if (bus.div_remainder !== 32'd0) begin errors++; $display("FAIL min_neg1 remainder: got %h expected 0", bus.div_remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL min_neg1 flag: got %b expected 0", bus.div_by_zero); end
        end_call();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_req_held();
        test_reset_mid();
        test_operand_churn();
        test_random();
`ifdef METHOD_DIV_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
